// File: rtl/spi_slave_rxpq_if.sv
// Pin-side SPI inputs plus the downstream ready/valid word stream of the receive packet queue.
interface spi_slave_rxpq_if #(
    parameter int W         = 8,
    parameter int LEN_DEPTH = 8
);
    logic                           cs;
    logic                           sclk;
    logic                           mosi;
    logic [W-1:0]                   rxd;
    logic                           rxdv;
    logic                           rxe;
    logic                           rxready;
    logic [$clog2(LEN_DEPTH+1)-1:0] frames_pending;
    logic [7:0]                     drop_cnt;

    modport slave (
        input  cs, sclk, mosi, rxready,
        output rxd, rxdv, rxe, frames_pending, drop_cnt
    );

    modport master (
        output cs, sclk, mosi, rxready,
        input  rxd, rxdv, rxe, frames_pending, drop_cnt
    );
endinterface

// File: rtl/spi_slave_rxpq.sv
// SPI slave receive packet queue: deserialises CS-framed SPI words, commits whole frames
// atomically, and replays each frame as header, optional length word and payload.
module spi_slave_rxpq #(
    parameter int           W         = 8,
    parameter int           DEPTH     = 256,
    parameter int           LEN_DEPTH = 8,
    parameter logic [W-1:0] HEADER    = W'(8'h99),
    parameter bit           LEN_WORD  = 1'b0
) (
    input  logic            c,
    input  logic            rst,
    spi_slave_rxpq_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int LAW = $clog2(LEN_DEPTH);
    localparam int LPW = LAW + 1;
    localparam int BCW = $clog2(W);
    localparam int FPW = $clog2(LEN_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, HDR, LEN, PAY} state_e;

    logic           cs_s1_q, cs_s2_q, cs_s3_q;
    logic           sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic           mosi_s1_q, mosi_s2_q;
    logic           armed_q, armed_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [BCW-1:0] bitcnt_q, bitcnt_d;
    logic           bad_q, bad_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  cnt_q, cnt_d;
    logic [LPW-1:0] lq_wr_q, lq_rd_q;
    logic [7:0]     drop_cnt_q, drop_cnt_d;
    state_e         state_q, state_d;

    logic [W-1:0]   mem    [DEPTH];
    logic [PW-1:0]  lq_mem [LEN_DEPTH];

    logic           cs_rise, sclk_rise, buf_full, lq_full, lq_empty;
    logic           mem_we, lq_push, lq_pop;
    logic [W-1:0]   word_w;
    logic [PW-1:0]  frame_len, head_len;

    assign cs_rise   = cs_s2_q & ~cs_s3_q;
    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign word_w    = {shift_q[W-2:0], mosi_s2_q};
    // Full uses the registered rd_ptr, so a same-cycle read never makes room early.
    assign buf_full  = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign lq_full   = (lq_wr_q - lq_rd_q) == LPW'(LEN_DEPTH);
    assign lq_empty  = (lq_wr_q == lq_rd_q);
    assign frame_len = wr_ptr_q - commit_ptr_q;
    assign head_len  = lq_mem[lq_rd_q[LAW-1:0]];

    assign bus.frames_pending = FPW'(lq_wr_q - lq_rd_q);
    assign bus.drop_cnt       = drop_cnt_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        armed_d      = armed_q | cs_s2_q;
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        bad_d        = bad_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_cnt_d   = drop_cnt_q;
        mem_we       = 1'b0;
        lq_push      = 1'b0;

        if (armed_q && !cs_s2_q && sclk_rise) begin
            shift_d = word_w;
            if (bitcnt_q == BCW'(W - 1)) begin
                bitcnt_d = '0;
                if (buf_full) begin
                    bad_d = 1'b1;
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
            end else begin
                bitcnt_d = bitcnt_q + BCW'(1);
            end
        end

        // Frame end: a partial word is discarded; the frame either commits whole or is rolled back.
        if (cs_rise) begin
            bitcnt_d = '0;
            shift_d  = '0;
            if (armed_q) begin
                bad_d = 1'b0;
                if (bad_q || (frame_len != '0 && lq_full)) begin
                    wr_ptr_d = commit_ptr_q;
                    if (drop_cnt_q != 8'hff) drop_cnt_d = drop_cnt_q + 8'd1;
                end else if (frame_len != '0) begin
                    commit_ptr_d = wr_ptr_q;
                    lq_push      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        lq_pop   = 1'b0;
        bus.rxd  = '0;
        bus.rxdv = 1'b0;
        bus.rxe  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!lq_empty) begin
                    state_d = HDR;
                    cnt_d   = head_len;
                end
            end
            HDR: begin
                bus.rxd  = HEADER;
                bus.rxdv = 1'b1;
                if (bus.rxready) state_d = LEN_WORD ? LEN : PAY;
            end
            LEN: begin
                bus.rxd  = W'(head_len);
                bus.rxdv = 1'b1;
                if (bus.rxready) state_d = PAY;
            end
            PAY: begin
                bus.rxd  = mem[rd_ptr_q[AW-1:0]];
                bus.rxdv = 1'b1;
                bus.rxe  = (cnt_q == PW'(1));
                if (bus.rxready) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    cnt_d    = cnt_q - PW'(1);
                    if (cnt_q == PW'(1)) begin
                        lq_pop  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            cs_s1_q      <= 1'b0;
            cs_s2_q      <= 1'b0;
            cs_s3_q      <= 1'b0;
            sclk_s1_q    <= 1'b0;
            sclk_s2_q    <= 1'b0;
            sclk_s3_q    <= 1'b0;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            armed_q      <= 1'b0;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            bad_q        <= 1'b0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            lq_wr_q      <= '0;
            lq_rd_q      <= '0;
            drop_cnt_q   <= '0;
            state_q      <= IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, so the synchroniser chains shift correctly.
            cs_s1_q      <= bus.cs;
            cs_s2_q      <= cs_s1_q;
            cs_s3_q      <= cs_s2_q;
            sclk_s1_q    <= bus.sclk;
            sclk_s2_q    <= sclk_s1_q;
            sclk_s3_q    <= sclk_s2_q;
            mosi_s1_q    <= bus.mosi;
            mosi_s2_q    <= mosi_s1_q;
            armed_q      <= armed_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            bad_q        <= bad_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            state_q      <= state_d;
            if (lq_push) lq_wr_q <= lq_wr_q + LPW'(1);
            if (lq_pop)  lq_rd_q <= lq_rd_q + LPW'(1);
        end
    end

    // NOTE: storage arrays carry no reset; the pointers guarantee no entry is read before it is written.
    always_ff @(posedge c) begin
        if (mem_we)  mem[wr_ptr_q[AW-1:0]]     <= word_w;
        if (lq_push) lq_mem[lq_wr_q[LAW-1:0]]  <= frame_len;
    end
endmodule

// File: tb/tb_spi_slave_rxpq.sv
// Directed bench for spi_slave_rxpq: default, LEN_WORD=1 and DEPTH=4 instances share the SPI pins.
module tb_spi_slave_rxpq;
    logic c    = 1'b0;
    logic rst  = 1'b0;
    logic cs   = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic rdy0 = 1'b0;
    logic rdy1 = 1'b0;
    logic rdy2 = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    spi_slave_rxpq_if #(.W(8), .LEN_DEPTH(8)) if0 ();
    spi_slave_rxpq_if #(.W(8), .LEN_DEPTH(8)) if1 ();
    spi_slave_rxpq_if #(.W(8), .LEN_DEPTH(8)) if2 ();

    assign if0.cs = cs;  assign if0.sclk = sclk;  assign if0.mosi = mosi;  assign if0.rxready = rdy0;
    assign if1.cs = cs;  assign if1.sclk = sclk;  assign if1.mosi = mosi;  assign if1.rxready = rdy1;
    assign if2.cs = cs;  assign if2.sclk = sclk;  assign if2.mosi = mosi;  assign if2.rxready = rdy2;

    spi_slave_rxpq #(.W(8))                    u_dut0 (.c(c), .rst(rst), .bus(if0));
    spi_slave_rxpq #(.W(8), .LEN_WORD(1'b1))   u_dut1 (.c(c), .rst(rst), .bus(if1));
    spi_slave_rxpq #(.W(8), .DEPTH(4))         u_dut2 (.c(c), .rst(rst), .bus(if2));

    always #5 c = ~c;

    // Accepted words as {rxe, rxd}, sampled on the falling edge before the accepting rising edge.
    logic [8:0] cap0[$];
    logic [8:0] cap1[$];
    logic [8:0] cap2[$];
    always @(negedge c) begin
        if (if0.rxdv && if0.rxready) cap0.push_back({if0.rxe, if0.rxd});
        if (if1.rxdv && if1.rxready) cap1.push_back({if1.rxe, if1.rxd});
        if (if2.rxdv && if2.rxready) cap2.push_back({if2.rxe, if2.rxd});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic       stab_en = 1'b0;
    logic       hold_v  = 1'b0;
    logic [8:0] hold_w  = '0;
    always @(negedge c) begin
        if (stab_en) begin
            if (hold_v) begin
                check("hold_rxdv", if0.rxdv, 1);
                check("hold_word", {if0.rxe, if0.rxd}, hold_w);
            end
            hold_v = if0.rxdv && !if0.rxready;
            hold_w = {if0.rxe, if0.rxd};
        end
    end

    function automatic int cap_size(input int d);
        case (d)
            0:       return cap0.size();
            1:       return cap1.size();
            default: return cap2.size();
        endcase
    endfunction

    function automatic logic [8:0] cap_get(input int d, input int i);
        if (i >= cap_size(d)) return 9'bx;
        case (d)
            0:       return cap0[i];
            1:       return cap1[i];
            default: return cap2[i];
        endcase
    endfunction

    task automatic spi_bits(input logic [63:0] bits, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = bits[i];
            #30 sclk = 1'b1;
            #30 sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [63:0] bits, input int nbits);
        cs = 1'b0;
        #40;
        spi_bits(bits, nbits);
        #40 cs = 1'b1;
        #80;
    endtask

    task automatic do_reset();
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(posedge c);
        #1 rst = 1'b0;
        repeat (4) @(posedge c);
        #1;
        cap0.delete(); cap1.delete(); cap2.delete();
    endtask

    task automatic wait_words(input int d, input int n, input string name);
        int t = 0;
        while (cap_size(d) < n && t < 200) begin
            @(posedge c);
            t++;
        end
        repeat (6) @(posedge c);
        #1;
        check({name, "_count"}, cap_size(d), n);
    endtask

    task automatic check_words(input int d, input string name, input int n,
                               input logic [7:0] exp [8], input logic [7:0] rxe_mask);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_w%0d", name, i), cap_get(d, i), {rxe_mask[i], exp[i]});
    endtask

    typedef struct {
        string       name;
        logic [63:0] bits;
        int          nbits;
        int          n_out;
        logic [7:0]  exp [8];
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e [8];
        logic [7:0] mask;

        vecs[0] = '{"three_bytes", 64'ha50751,   24, 4, '{8'h99, 8'ha5, 8'h07, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[1] = '{"four_bytes",  64'hff80017e, 32, 5, '{8'h99, 8'hff, 8'h80, 8'h01, 8'h7e, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{"twelve_edge", 64'h3ca,      12, 2, '{8'h99, 8'h3c, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{"zero_edge",   64'h0,         0, 0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[4] = '{"zero_byte",   64'h00,        8, 2, '{8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[5] = '{"seven_bits",  64'h7f,        7, 0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

        #1 rst = 1'b1;
        repeat (2) @(posedge c);
        #1;
        check("rst_rxd",     if0.rxd, 0);
        check("rst_rxdv",    if0.rxdv, 0);
        check("rst_rxe",     if0.rxe, 0);
        check("rst_pending", if0.frames_pending, 0);
        check("rst_drop",    if0.drop_cnt, 0);
        do_reset();

        // Table: one frame at a time on the default instance, held first, then drained.
        foreach (vecs[v]) begin
            rdy0 = 1'b0;
            cap0.delete();
            spi_frame(vecs[v].bits, vecs[v].nbits);
            repeat (4) @(posedge c);
            #1;
            check({vecs[v].name, "_pending"}, if0.frames_pending, (vecs[v].n_out > 0) ? 1 : 0);
            check({vecs[v].name, "_held_rxdv"}, if0.rxdv, (vecs[v].n_out > 0) ? 1 : 0);
            check({vecs[v].name, "_drop"}, if0.drop_cnt, 0);
            rdy0 = 1'b1;
            wait_words(0, vecs[v].n_out, vecs[v].name);
            mask = (vecs[v].n_out > 0) ? (8'd1 << (vecs[v].n_out - 1)) : 8'd0;
            check_words(0, vecs[v].name, vecs[v].n_out, vecs[v].exp, mask);
            check({vecs[v].name, "_pending_after"}, if0.frames_pending, 0);
        end

        // LEN_WORD=1: two frames queued behind backpressure, then drained back to back.
        do_reset();
        rdy1 = 1'b0;
        spi_frame(64'h1122, 16);
        spi_frame(64'h33, 8);
        repeat (4) @(posedge c);
        #1;
        check("lenw_pending2", if1.frames_pending, 2);
        check("lenw_held_hdr", {if1.rxdv, if1.rxd}, 9'h199);
        rdy1 = 1'b1;
        wait_words(1, 7, "lenw");
        e = '{8'h99, 8'h02, 8'h11, 8'h22, 8'h99, 8'h01, 8'h33, 8'h00};
        check_words(1, "lenw", 7, e, 8'b0100_1000);
        check("lenw_pending0", if1.frames_pending, 0);

        // DEPTH=4: 5-byte frame overflows behind a queued 2-byte frame and is dropped whole.
        do_reset();
        rdy2 = 1'b0;
        spi_frame(64'haabb, 16);
        spi_frame(64'h0102030405, 40);
        spi_frame(64'hccdd, 16);
        repeat (4) @(posedge c);
        #1;
        check("ovf_drop", if2.drop_cnt, 1);
        check("ovf_pending", if2.frames_pending, 2);
        rdy2 = 1'b1;
        wait_words(2, 6, "ovf");
        e = '{8'h99, 8'haa, 8'hbb, 8'h99, 8'hcc, 8'hdd, 8'h00, 8'h00};
        check_words(2, "ovf", 6, e, 8'b0010_0100);
        check("ovf_drop_after", if2.drop_cnt, 1);
        check("ovf_pending_after", if2.frames_pending, 0);

        // rxready toggling every cycle: held words must stay put until accepted.
        do_reset();
        rdy0 = 1'b0;
        spi_frame(64'h12345678, 32);
        repeat (4) @(posedge c);
        #1;
        hold_v  = 1'b0;
        stab_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rdy0 = ~rdy0;
            @(posedge c);
            #1;
        end
        stab_en = 1'b0;
        rdy0 = 1'b1;
        wait_words(0, 5, "toggle");
        e = '{8'h99, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00};
        check_words(0, "toggle", 5, e, 8'b0001_0000);

        // Reset mid-frame with a frame queued; release with cs low, then that frame must be ignored.
        do_reset();
        rdy0 = 1'b0;
        spi_frame(64'h5a, 8);
        repeat (4) @(posedge c);
        #1;
        check("midrst_queued_rxdv", if0.rxdv, 1);
        cs = 1'b0;
        #40;
        spi_bits(64'hf, 4);
        rst = 1'b1;
        #1;
        check("midrst_rxdv_async", if0.rxdv, 0);
        repeat (2) @(negedge c);
        check("midrst_rxd",     if0.rxd, 0);
        check("midrst_rxe",     if0.rxe, 0);
        check("midrst_pending", if0.frames_pending, 0);
        check("midrst_drop",    if0.drop_cnt, 0);
        @(posedge c);
        #1 rst = 1'b0;
        cap0.delete();
        rdy0 = 1'b1;
        spi_bits(64'hff, 8);
        #40 cs = 1'b1;
        #80;
        wait_words(0, 0, "midrst_ignored");
        check("midrst_pending_after", if0.frames_pending, 0);
        spi_frame(64'hc3, 8);
        wait_words(0, 2, "midrst_fresh");
        e = '{8'h99, 8'hc3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_words(0, "midrst_fresh", 2, e, 8'b0000_0010);
        check("midrst_drop_after", if0.drop_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
